// File: rtl/lzrw1_group_sequencer_if.sv
// Byte-stream input and item-issue handshake between the input FIFO, the
// LZRW1 group sequencer and the decompressor core.
interface lzrw1_group_sequencer_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] item_data;
  logic        item_ctrl;
  logic        item_valid;
  logic        decomp_busy;
  logic        frame_done;
  logic        proto_error;

  modport master (
    output in_byte, in_valid, in_last, decomp_busy,
    input  in_ready, item_data, item_ctrl, item_valid, frame_done, proto_error
  );

  modport slave (
    input  in_byte, in_valid, in_last, decomp_busy,
    output in_ready, item_data, item_ctrl, item_valid, frame_done, proto_error
  );
endinterface

// File: rtl/lzrw1_group_sequencer.sv
// LZRW1 front-end: parses 16-bit control words and their items, issues one item
// at a time to the core. Optional copy sanity check: LZRW1_SEQ_COPY_CHECK_EN.
module lzrw1_group_sequencer #(
  parameter int unsigned GROUP_ITEMS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  lzrw1_group_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    CTRL_LO,
    CTRL_HI,
    ITEM_B0,
    ITEM_B1,
    CHECK,
    ISSUE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(GROUP_ITEMS - 1);

  state_t      state_q, state_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] data_q, data_d;
  logic        kind_q, kind_d;
  logic        end_q, end_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accepting;
  logic        byte_xfer;
  logic        last_item;

  assign accepting = !reset && (state_q == CTRL_LO || state_q == CTRL_HI ||
                                state_q == ITEM_B0 || state_q == ITEM_B1);
  assign byte_xfer = bus.in_valid && accepting;
  assign last_item = (idx_q == LAST_IDX);

  assign bus.in_ready    = accepting;
  assign bus.item_valid  = (state_q == ISSUE);
  assign bus.item_data   = data_q;
  assign bus.item_ctrl   = kind_q;
  assign bus.frame_done  = done_q;
  assign bus.proto_error = err_q;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    data_d  = data_q;
    kind_d  = kind_q;
    end_d   = end_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      CTRL_LO: if (byte_xfer) begin
        if (bus.in_last) err_d = 1'b1;
        else begin
          ctrl_d[7:0] = bus.in_byte;
          state_d     = CTRL_HI;
        end
      end
      CTRL_HI: if (byte_xfer) begin
        if (bus.in_last) begin
          err_d   = 1'b1;
          state_d = CTRL_LO;
        end else begin
          ctrl_d[15:8] = bus.in_byte;
          idx_d        = '0;
          state_d      = ITEM_B0;
        end
      end
      ITEM_B0: if (byte_xfer) begin
        if (!ctrl_q[idx_q]) begin
          data_d  = {8'h00, bus.in_byte};
          kind_d  = 1'b0;
          end_d   = bus.in_last;
          state_d = ISSUE;
        end else if (bus.in_last) begin
          // A frame cannot end halfway through a copy item.
          err_d   = 1'b1;
          state_d = CTRL_LO;
        end else begin
          hold_d  = bus.in_byte;
          state_d = ITEM_B1;
        end
      end
      ITEM_B1: if (byte_xfer) begin
        data_d  = {hold_q, bus.in_byte};
        kind_d  = 1'b1;
        end_d   = bus.in_last;
`ifdef LZRW1_SEQ_COPY_CHECK_EN
        state_d = CHECK;
`else
        state_d = ISSUE;
`endif
      end
`ifdef LZRW1_SEQ_COPY_CHECK_EN
      CHECK: begin
        if (data_q[15:12] == 4'h0 || data_q[11:0] == 12'h000) begin
          // Bad copy is swallowed like a transferred item, minus frame_done.
          err_d = 1'b1;
          end_d = 1'b0;
          if (end_q || last_item) state_d = CTRL_LO;
          else begin
            idx_d   = idx_q + 4'd1;
            state_d = ITEM_B0;
          end
        end else begin
          state_d = ISSUE;
        end
      end
`endif
      ISSUE: if (!bus.decomp_busy) begin
        done_d = end_q;
        end_d  = 1'b0;
        if (end_q || last_item) state_d = CTRL_LO;
        else begin
          idx_d   = idx_q + 4'd1;
          state_d = ITEM_B0;
        end
      end
      default: state_d = CTRL_LO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CTRL_LO;
      ctrl_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      kind_q  <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
      end_q   <= end_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lzrw1_group_sequencer.sv
// Self-checking bench for lzrw1_group_sequencer: directed scenarios plus random
// frames checked against an item-list reference encoder.
`timescale 1ns/1ps
module tb_lzrw1_group_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lzrw1_group_sequencer_if bus ();

  lzrw1_group_sequencer #(.GROUP_ITEMS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [16:0] got_q[$];
  int  done_cnt      = 0;
  int  cyc           = 0;
  int  last_xfer_cyc = -10;
  int  done_cyc      = -10;
  bit  gap_en        = 1'b0;

  // Observe item transfers and frame_done pulses on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (bus.item_valid && !bus.decomp_busy) begin
        got_q.push_back({bus.item_ctrl, bus.item_data});
        last_xfer_cyc = cyc;
      end
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n;
    if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    bus.in_byte  = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (bus.in_ready) break;
      n++;
      if (n > 300) begin
        compared++;
        mismatched++;
        $display("FAIL byte_accept_timeout in_ready=%b required 1", bus.in_ready);
        break;
      end
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_items(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 3000) begin @(negedge clock); k++; end
    repeat (3) @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_byte = 8'h00; bus.decomp_busy = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    obs = {bus.in_ready, bus.item_valid, bus.item_data, bus.item_ctrl, bus.frame_done, bus.proto_error};
    compared++;
    if (obs !== 21'h0) begin
      mismatched++;
      $display("FAIL reset_outputs got %h required %h", obs, 21'h0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_reset got %b required 1", bus.in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_literals();
    logic [7:0] b;
    got_q.delete(); done_cnt = 0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      b = 8'h41 + 8'(i);
      send_byte(b, i == 15);
    end
    wait_items(16);
    compared++;
    if (got_q.size() != 16) begin
      mismatched++;
      $display("FAIL lit_count got %0d required 16", got_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== {1'b0, 16'h0041 + 16'(i)}) begin
        mismatched++;
        $display("FAIL lit_item[%0d] got %h required %h", i, got_q[i], {1'b0, 16'h0041 + 16'(i)});
      end
    end
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL lit_frame_done got %0d required 1", done_cnt);
    end
    compared++;
    if (done_cyc !== last_xfer_cyc + 1) begin
      mismatched++;
      $display("FAIL lit_done_timing got cycle %0d required %0d", done_cyc, last_xfer_cyc + 1);
    end
  endtask

  task automatic test_mixed();
    logic [16:0] exp_q[$];
    got_q.delete(); done_cnt = 0;
    exp_q = '{{1'b0, 16'h0061}, {1'b1, 16'h3005}, {1'b0, 16'h0062}};
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h61, 1'b0);
    send_byte(8'h30, 1'b0); send_byte(8'h05, 1'b0);
    send_byte(8'h62, 1'b1);
    wait_items(3);
    compared++;
    if (got_q.size() != 3) begin
      mismatched++;
      $display("FAIL mixed_count got %0d required 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL mixed_item[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL mixed_frame_done got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_busy_stall();
    logic [18:0] obs;
    int k;
    got_q.delete(); done_cnt = 0;
    bus.decomp_busy = 1'b1;
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b0); send_byte(8'h05, 1'b1);
    bus.in_byte  = 8'hAA;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.item_valid && k < 5) begin @(negedge clock); k++; end
    compared++;
    if (bus.item_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_valid_rise got %b required 1", bus.item_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      obs = {bus.item_valid, bus.item_data, bus.item_ctrl, bus.in_ready};
      compared++;
      if (obs !== {1'b1, 16'h3005, 1'b1, 1'b0}) begin
        mismatched++;
        $display("FAIL stall_hold[%0d] got %h required %h", i, obs, {1'b1, 16'h3005, 1'b1, 1'b0});
      end
    end
    @(posedge clock); #1;
    bus.in_valid    = 1'b0;
    bus.decomp_busy = 1'b0;
    wait_items(1);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 16'h3005}) begin
      mismatched++;
      $display("FAIL stall_item got n=%0d %h required n=1 %h", got_q.size(), got_q[0], {1'b1, 16'h3005});
    end
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL stall_frame_done got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_proto_error();
    got_q.delete(); done_cnt = 0;
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b1);
    repeat (3) @(negedge clock);
    compared++;
    if (bus.proto_error !== 1'b1 || got_q.size() != 0 || done_cnt != 0) begin
      mismatched++;
      $display("FAIL proto_detect got err=%b items=%0d done=%0d required err=1 items=0 done=0",
               bus.proto_error, got_q.size(), done_cnt);
    end
    @(posedge clock); #1;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h7A, 1'b1);
    wait_items(1);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 16'h007A}) begin
      mismatched++;
      $display("FAIL proto_recover_item got n=%0d %h required n=1 %h", got_q.size(), got_q[0], {1'b0, 16'h007A});
    end
    compared++;
    if (done_cnt !== 1 || bus.proto_error !== 1'b1) begin
      mismatched++;
      $display("FAIL proto_recover_state got done=%0d err=%b required done=1 err=1", done_cnt, bus.proto_error);
    end
  endtask

  task automatic test_reset_mid_item();
    logic [20:0] obs;
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    obs = {bus.in_ready, bus.item_valid, bus.item_data, bus.item_ctrl, bus.frame_done, bus.proto_error};
    compared++;
    if (obs !== {1'b1, 20'h0}) begin
      mismatched++;
      $display("FAIL midreset_outputs got %h required %h", obs, {1'b1, 20'h0});
    end
    @(posedge clock); #1;
    got_q.delete(); done_cnt = 0;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h7A, 1'b1);
    wait_items(1);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 16'h007A} || done_cnt != 1) begin
      mismatched++;
      $display("FAIL midreset_fresh got n=%0d %h done=%0d required n=1 %h done=1",
               got_q.size(), got_q[0], done_cnt, {1'b0, 16'h007A});
    end
  endtask

  task automatic test_random();
    logic [16:0] exp_q[$];
    logic [8:0]  byte_q[$];
    logic [8:0]  tmp;
    logic [15:0] cw;
    int n;
    bit stop;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int f = 0; f < 6; f++) begin
      exp_q.delete(); byte_q.delete(); got_q.delete(); done_cnt = 0;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1)
          exp_q.push_back({1'b1, 4'($urandom_range(1, 15)), 12'($urandom_range(1, 4095))});
        else
          exp_q.push_back({1'b0, 8'h00, 8'($urandom)});
      end
      for (int g = 0; g < n; g += 16) begin
        cw = 16'($urandom);
        for (int k = 0; k < 16 && g + k < n; k++) cw[k] = exp_q[g + k][16];
        byte_q.push_back({1'b0, cw[7:0]});
        byte_q.push_back({1'b0, cw[15:8]});
        for (int k = 0; k < 16 && g + k < n; k++) begin
          if (exp_q[g + k][16]) byte_q.push_back({1'b0, exp_q[g + k][15:8]});
          byte_q.push_back({1'b0, exp_q[g + k][7:0]});
        end
      end
      tmp = byte_q.pop_back();
      tmp[8] = 1'b1;
      byte_q.push_back(tmp);
      stop   = 1'b0;
      gap_en = 1'b1;
      fork
        begin
          foreach (byte_q[i]) send_byte(byte_q[i][7:0], byte_q[i][8]);
          wait_items(n);
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            @(posedge clock); #1;
            bus.decomp_busy = ($urandom_range(0, 3) == 0);
          end
          bus.decomp_busy = 1'b0;
        end
      join
      bus.decomp_busy = 1'b0;
      gap_en = 1'b0;
      compared++;
      if (got_q.size() != n) begin
        mismatched++;
        $display("FAIL rand[%0d]_count got %0d required %0d", f, got_q.size(), n);
      end
      for (int i = 0; i < n; i++) begin
        compared++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL rand[%0d]_item[%0d] got %h required %h", f, i,
                   (i < got_q.size()) ? got_q[i] : 17'hx, exp_q[i]);
        end
      end
      compared++;
      if (done_cnt !== 1) begin
        mismatched++;
        $display("FAIL rand[%0d]_frame_done got %0d required 1", f, done_cnt);
      end
    end
    compared++;
    if (bus.proto_error !== 1'b0) begin
      mismatched++;
      $display("FAIL rand_proto_error got %b required 0", bus.proto_error);
    end
  endtask

  task automatic test_copy_check();
    got_q.delete(); done_cnt = 0;
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b1);
`ifdef LZRW1_SEQ_COPY_CHECK_EN
    wait_items(0);
    compared++;
    if (got_q.size() != 0 || done_cnt != 0 || bus.proto_error !== 1'b1) begin
      mismatched++;
      $display("FAIL copy_check got n=%0d done=%0d err=%b required n=0 done=0 err=1",
               got_q.size(), done_cnt, bus.proto_error);
    end
`else
    wait_items(1);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 16'h2000} || done_cnt != 1 || bus.proto_error !== 1'b0) begin
      mismatched++;
      $display("FAIL copy_unchecked got n=%0d %h done=%0d err=%b required n=1 %h done=1 err=0",
               got_q.size(), got_q[0], done_cnt, bus.proto_error, {1'b1, 16'h2000});
    end
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_literals();
    test_mixed();
    test_busy_stall();
    test_proto_error();
    test_reset_mid_item();
    test_random();
    test_copy_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lzrw1_group_sequencer.md
# lzrw1_group_sequencer

Front-end controller for the LZRW1 decompressor. It consumes the byte-wide compressed stream and parses each 16-bit control word and its up-to-16 items. It issues one item at a time to the decompressor core on `data_in` / `control_word_in` / `in_data_valid`, pacing issue against the core's `decompressor_busy`. It sits between the input byte FIFO and the decompressor core, and it owns group/frame framing and protocol-error detection.

## Interface
- `GROUP_ITEMS`, default 16: items per control word; must be 16 (control word is 16 bits).
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `in_byte`  in  8  compressed-stream byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_last`  in  1  `in_byte` is the final byte of the frame.
- `in_ready`  out  1  sequencer accepts `in_byte` this cycle.
- `item_data`  out  16  to core `data_in`: literal is {8'h00, byte}; copy is {length[3:0], offset[11:0]}.
- `item_ctrl`  out  1  to core `control_word_in`: 0 = literal, 1 = copy.
- `item_valid`  out  1  to core `in_data_valid`.
- `decomp_busy`  in  1  from core `decompressor_busy`.
- `frame_done`  out  1  one-cycle pulse when the last item of a frame is handed off.
- `proto_error`  out  1  sticky framing error; cleared only by `reset`.

## Operation
- Byte transfer: occurs when `in_valid && in_ready`.
- Item transfer: occurs when `item_valid && !decomp_busy`.
- FSM states and `in_ready` per state:
  - CTRL_LO (`in_ready`=1): accepted byte → ctrl[7:0]; next state CTRL_HI.
  - CTRL_HI (`in_ready`=1): accepted byte → ctrl[15:8]; `idx`←0; next state ITEM_B0.
  - ITEM_B0 (`in_ready`=1):
    - If ctrl[idx]=0: `item_data`←{8'h00, byte}, `item_ctrl`←0, next state ISSUE.
    - If ctrl[idx]=1: hold byte as {length, offset[11:8]}, next state ITEM_B1.
  - ITEM_B1 (`in_ready`=1): `item_data`←{held byte, byte}, `item_ctrl`←1, next state ISSUE.
  - ISSUE (`in_ready`=0, `item_valid`=1): `item_data` / `item_ctrl` held stable until the item transfer.
    - On transfer: if the frame is ending, pulse `frame_done` and go to CTRL_LO.
    - Else if `idx`=15, go to CTRL_LO.
    - Else `idx`+1 and go to ITEM_B0.
- Control bits are consumed LSB first; `idx` is a 4-bit counter wrapping 15→0 only via CTRL_HI.
- Frame end: `in_last` on the final byte of an item (ITEM_B0 literal, or ITEM_B1) marks the frame as ending. Remaining ctrl bits of a partial group are discarded.
- Protocol error: `in_last` accepted in CTRL_LO, in CTRL_HI, or in ITEM_B0 with ctrl[idx]=1.
  - The byte is consumed, `proto_error`←1, next state is CTRL_LO.
  - No item is issued and no `frame_done` is generated.
  - The sequencer continues parsing the next frame normally.
- Out of reset: the first byte is a control-word low byte.

## Timing
- Reset values: `in_ready`=0 while `reset` is high. `item_valid`=0, `item_data`=16'h0000, `item_ctrl`=0, `frame_done`=0, `proto_error`=0, state CTRL_LO, `idx`=0. `in_ready`=1 in the first cycle after `reset` deasserts.
- Latency: `item_valid` rises the cycle after the item's final byte is accepted.
- Best-case throughput: a literal takes 2 cycles; a copy takes 3 cycles; each control word costs 2 cycles.
- `frame_done` is asserted in the cycle after the final item transfer, for exactly 1 cycle.
- `decomp_busy` is high for the whole copy expansion. ISSUE stalls with outputs stable; there is no timeout.
- `decomp_busy` is ignored outside ISSUE.
- Reset mid-group or during ISSUE: the partial group and pending item are dropped. All outputs take reset values at that edge.
- `in_valid` low in any accepting state: the state holds and nothing changes.

## Configuration
- `LZRW1_SEQ_COPY_CHECK_EN` defined:
  - A copy item with offset==12'h000 or length==4'h0 is not issued.
  - `proto_error`←1, and the item is treated as consumed: `idx` advances, or a pending frame end completes without `frame_done`.
  - The check adds one cycle in ISSUE before `item_valid` is asserted, for copy items only.
- Undefined: copy items are issued unchecked, with the latencies above.

## Test plan
- Reset, then bytes 8'h00, 8'h00 then literals 8'h41..8'h50 (`in_last` on 8'h50) with `decomp_busy`=0:
  - 16 items with `item_ctrl`=0 and `item_data`=16'h0041..16'h0050, in order.
  - `frame_done` pulses once.
- Control bytes 8'h02, 8'h00, then items 8'h61, copy 8'h30, 8'h05, then 8'h62 with `in_last`:
  - items are {16'h0061,0}, {16'h3005,1}, {16'h0062,0}, then `frame_done`.
- Hold `decomp_busy`=1 for 10 cycles during ISSUE of a copy: `item_valid`, `item_data` and `item_ctrl` stay stable, `in_ready`=0, and no byte is consumed.
- `in_last` on the first byte of a copy item: no item is issued, `proto_error`=1 and stays 1. The next frame (8'h00, 8'h00, 8'h7A with `in_last`) still yields {16'h007A,0} and `frame_done`.
- Assert `reset` for 1 cycle while in ITEM_B1: all outputs read reset values after the edge. A fresh frame then parses from its control word.
- With `LZRW1_SEQ_COPY_CHECK_EN` defined: copy bytes 8'h20, 8'h00 are not issued and `proto_error`=1. Without the macro, the same bytes issue {16'h2000,1}.
